// File: rtl/elevator_motion_controller.sv
// -----------------------------------------------------------------------------
// elevator_motion_controller
//
// Car motion / door sequencer sitting directly after direction_checker.
// The car moves one floor per travel interval, opens its door at requested
// floors and reports each served floor so the upstream request register can
// clear that bit. Scheduling is SCAN: keep going while requests remain ahead,
// otherwise reverse.
//
// Ports
//   clk                rising-edge system clock
//   rst_n              asynchronous active-low reset
//   floor_requests     pending requests, bit i = floor i
//   has_request_above  any request above current_floor (from direction_checker)
//   has_request_below  any request below current_floor (from direction_checker)
//   current_floor      registered car position, fed back to direction_checker
//   moving_up          high while travelling up
//   moving_down        high while travelling down
//   door_open          high while the door is open
//   served_valid       one-cycle pulse on the first door-open cycle
//   served_floor       floor being served, valid with served_valid
// -----------------------------------------------------------------------------
module elevator_motion_controller #(
    parameter int NUM_FLOORS    = 10,
    parameter int FLOOR_WIDTH   = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_FLOORS-1:0]  floor_requests,
    input  logic                   has_request_above,
    input  logic                   has_request_below,
    output logic [FLOOR_WIDTH-1:0] current_floor,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open,
    output logic                   served_valid,
    output logic [FLOOR_WIDTH-1:0] served_floor
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]          TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]          DOOR_LAST   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);
    localparam logic [FLOOR_WIDTH-1:0] ONE_FLOOR   = FLOOR_WIDTH'(1);

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        CHECK     = 3'd3,
        DOOR_OPEN = 3'd4
    } state_t;

    state_t                   state, state_n, dec_state;
    logic                     dir_pref, dir_n, dec_dir;
    logic [TW-1:0]            timer, timer_n;
    logic [FLOOR_WIDTH-1:0]   floor_n;
    logic                     here_req;
    logic                     ahead_req, behind_req;

    assign here_req   = floor_requests[current_floor];
    // Flags seen from the car's preferred direction of travel.
    assign ahead_req  = (dir_pref == DIR_UP) ? has_request_above : has_request_below;
    assign behind_req = (dir_pref == DIR_UP) ? has_request_below : has_request_above;

    // Shared decision used from IDLE and CHECK: serve here first, then keep
    // the current direction, then reverse, else rest.
    always_comb begin
        dec_state = IDLE;
        dec_dir   = dir_pref;
        if (here_req) begin
            dec_state = DOOR_OPEN;
        end else if (ahead_req) begin
            dec_state = (dir_pref == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (behind_req) begin
            dec_dir   = ~dir_pref;
            dec_state = (dir_pref == DIR_UP) ? MOVE_DOWN : MOVE_UP;
        end
    end

    // Next-state logic. The timer only runs while staying in a timed state;
    // any state change restarts it from zero.
    always_comb begin
        state_n = state;
        dir_n   = dir_pref;
        floor_n = current_floor;
        timer_n = '0;
        case (state)
            IDLE, CHECK: begin
                state_n = dec_state;
                dir_n   = dec_dir;
            end
            MOVE_UP: begin
                // Never step past the top floor, even if the flags disagree.
                if (current_floor == TOP_FLOOR) begin
                    state_n = CHECK;
                    dir_n   = ~dir_pref;
                end else if (timer == TRAVEL_LAST) begin
                    state_n = CHECK;
                    floor_n = current_floor + ONE_FLOOR;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (current_floor == '0) begin
                    state_n = CHECK;
                    dir_n   = ~dir_pref;
                end else if (timer == TRAVEL_LAST) begin
                    state_n = CHECK;
                    floor_n = current_floor - ONE_FLOOR;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DOOR_OPEN: begin
                // Requests at this floor are ignored while the door is open.
                if (timer == DOOR_LAST) begin
                    state_n = CHECK;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dir_pref      <= DIR_UP;
            timer         <= '0;
            current_floor <= '0;
        end else begin
            state         <= state_n;
            dir_pref      <= dir_n;
            timer         <= timer_n;
            current_floor <= floor_n;
        end
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moving_up    <= 1'b0;
            moving_down  <= 1'b0;
            door_open    <= 1'b0;
            served_valid <= 1'b0;
            served_floor <= '0;
        end else begin
            moving_up    <= (state_n == MOVE_UP);
            moving_down  <= (state_n == MOVE_DOWN);
            door_open    <= (state_n == DOOR_OPEN);
            served_valid <= (state_n == DOOR_OPEN) && (state != DOOR_OPEN);
            if ((state_n == DOOR_OPEN) && (state != DOOR_OPEN)) begin
                served_floor <= current_floor;
            end
        end
    end

endmodule

// File: tb/tb_elevator_motion_controller.sv
// -----------------------------------------------------------------------------
// tb_elevator_motion_controller
//
// Self-checking bench: a duration-based behavioural model of the car runs in
// lock-step with the DUT and every output is compared once per cycle. A small
// direction_checker model closes the current_floor feedback loop.
// -----------------------------------------------------------------------------
module tb_elevator_motion_controller;

    localparam int NF   = 10;
    localparam int FW   = 4;
    localparam int TRV  = 8;
    localparam int DOOR = 16;

    localparam int A_IDLE = 0;
    localparam int A_UP   = 1;
    localparam int A_DN   = 2;
    localparam int A_CHK  = 3;
    localparam int A_OPEN = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] floor_requests;
    logic          force_above;
    logic          has_request_above, has_request_below;
    logic [FW-1:0] current_floor, served_floor;
    logic          moving_up, moving_down, door_open, served_valid;

    int asserts = 0;
    int fails   = 0;

    // model state
    int m_act, m_left, m_floor, m_sfloor;
    bit m_dir_up, m_served;

    bit rand_en = 0;
    int max_seen = 0;
    int served_log[$];

    always #5 clk = ~clk;

    function automatic logic dc_above(input logic [NF-1:0] r, input int f);
        for (int i = 0; i < NF; i++) if (i > f && r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic dc_below(input logic [NF-1:0] r, input int f);
        for (int i = 0; i < NF; i++) if (i < f && r[i]) return 1'b1;
        return 1'b0;
    endfunction

    assign has_request_above = dc_above(floor_requests, int'(current_floor)) | force_above;
    assign has_request_below = dc_below(floor_requests, int'(current_floor));

    elevator_motion_controller #(
        .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .TRAVEL_CYCLES(TRV), .DOOR_CYCLES(DOOR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .floor_requests(floor_requests),
        .has_request_above(has_request_above),
        .has_request_below(has_request_below),
        .current_floor(current_floor),
        .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open),
        .served_valid(served_valid), .served_floor(served_floor)
    );

    task automatic chk(input string tag, input int got, input int exp);
        asserts++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_act = A_IDLE; m_left = 0; m_floor = 0; m_dir_up = 1'b1;
        m_served = 1'b0; m_sfloor = 0;
    endtask

    task automatic m_start_move(input bit up);
        m_act  = up ? A_UP : A_DN;
        m_left = TRV;
    endtask

    // Predict the car after the coming rising edge from the inputs in force now.
    task automatic m_step();
        bit ab, bl, ahead, behind;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_served = 1'b0;
        ab = dc_above(floor_requests, m_floor) | force_above;
        bl = dc_below(floor_requests, m_floor);
        case (m_act)
            A_IDLE, A_CHK: begin
                ahead  = m_dir_up ? ab : bl;
                behind = m_dir_up ? bl : ab;
                if (floor_requests[m_floor]) begin
                    m_act = A_OPEN; m_left = DOOR; m_served = 1'b1; m_sfloor = m_floor;
                end else if (ahead) begin
                    m_start_move(m_dir_up);
                end else if (behind) begin
                    m_dir_up = !m_dir_up;
                    m_start_move(m_dir_up);
                end else begin
                    m_act = A_IDLE;
                end
            end
            A_UP: begin
                if (m_floor == NF - 1) begin
                    m_act = A_CHK; m_dir_up = !m_dir_up;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_floor++; m_act = A_CHK; end
                end
            end
            A_DN: begin
                if (m_floor == 0) begin
                    m_act = A_CHK; m_dir_up = !m_dir_up;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_floor--; m_act = A_CHK; end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_act = A_CHK;
            end
        endcase
    endtask

    // One clock: stimulus for the coming edge, model step, compare after it.
    task automatic tick();
        if (m_served) floor_requests[m_sfloor] = 1'b0;
        if (rand_en && $urandom_range(0, 19) == 0)
            floor_requests[$urandom_range(0, NF - 1)] = 1'b1;
        m_step();
        @(negedge clk);
        chk("floor",   int'(current_floor), m_floor);
        chk("up",      int'(moving_up),     int'(m_act == A_UP));
        chk("down",    int'(moving_down),   int'(m_act == A_DN));
        chk("door",    int'(door_open),     int'(m_act == A_OPEN));
        chk("served",  int'(served_valid),  int'(m_served));
        chk("sfloor",  int'(served_floor),  m_sfloor);
        if (int'(current_floor) > max_seen) max_seen = int'(current_floor);
        if (served_valid) served_log.push_back(int'(served_floor));
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        do begin tick(); n++; end while (m_act != A_IDLE && n < limit);
        chk(tag, int'({moving_up, moving_down, door_open}), 0);
        chk({tag, "_bound"}, int'(n < limit), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; floor_requests = '0; force_above = 1'b0;
        m_reset();

        // 1: reset, then a quiet idle period
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        chk("t1_floor", int'(current_floor), 0);

        // 2: request at the current floor while idle
        floor_requests[0] = 1'b1;
        tick();
        chk("t2_door", int'(door_open), 1);
        chk("t2_sv",   int'(served_valid), 1);
        chk("t2_sf",   int'(served_floor), 0);
        repeat (15) tick();
        chk("t2_door_held", int'(door_open), 1);
        chk("t2_sv_once",   int'(served_valid), 0);
        tick();
        chk("t2_door_closed", int'(door_open), 0);
        wait_idle("t2_idle", 50);

        // 3: floor 0 -> 3, latency 1 + 3*(TRV+1)
        floor_requests[3] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!door_open && n < 200);
        chk("t3_lat", n, 1 + 3 * (TRV + 1));
        chk("t3_sf",  int'(served_floor), 3);
        chk("t3_up",  int'(moving_up), 0);
        wait_idle("t3_idle", 100);

        // 4: from 5 heading up, requests {2,7}: serve 7 then 2
        floor_requests[5] = 1'b1;
        wait_idle("t4_pos", 200);
        chk("t4_at5", int'(current_floor), 5);
        served_log.delete();
        floor_requests[2] = 1'b1;
        floor_requests[7] = 1'b1;
        wait_idle("t4_idle", 400);
        chk("t4_cnt", served_log.size(), 2);
        chk("t4_first",  (served_log.size() > 0) ? served_log[0] : -1, 7);
        chk("t4_second", (served_log.size() > 1) ? served_log[1] : -1, 2);

        // 5: top floor with a spurious 'above' flag
        floor_requests[9] = 1'b1;
        wait_idle("t5_pos", 400);
        floor_requests[9] = 1'b1;
        force_above = 1'b1;
        tick();
        chk("t5_door", int'(door_open), 1);
        chk("t5_sf",   int'(served_floor), 9);
        repeat (17) tick();
        chk("t5_up9",    int'(moving_up), 1);
        chk("t5_floor9", int'(current_floor), 9);
        tick();
        chk("t5_guard",  int'(moving_up), 0);
        repeat (10) tick();
        force_above = 1'b0;
        wait_idle("t5_idle", 50);
        chk("t5_max", max_seen, 9);

        // 6: asynchronous reset mid-travel at floor 4 going down
        floor_requests[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(m_floor == 4 && m_act == A_DN) && n < 400);
        chk("t6_reach", int'(moving_down), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_floor", int'(current_floor), 0);
        chk("t6_async_flags",
            int'({moving_up, moving_down, door_open, served_valid}), 0);
        chk("t6_async_sf", int'(served_floor), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t6_resume_door", int'(door_open), 1);
        chk("t6_resume_sf",   int'(served_floor), 0);
        wait_idle("t6_idle", 100);

        // 7: randomized request traffic
        rand_en = 1'b1;
        repeat (1500) tick();
        rand_en = 1'b0;
        wait_idle("t7_idle", 2000);
        chk("t7_drained", int'(floor_requests), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
